instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: ADDR_W, default 64, width of the program counter and instruction-memory address.
REQ-002 Port: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: Reset  input  1  reset, synchronous and active-high.
REQ-004 Port: StartPC  input  ADDR_W  PC value loaded on reset.
REQ-005 Port: imem_req  output  1  instruction-memory read request.
REQ-006 Port: imem_addr  output  ADDR_W  read address; equals PC.
REQ-007 Port: imem_ack  input  1  memory read data valid; honoured only while imem_req=1.
REQ-008 Port: imem_rdata  input  32  instruction word; sampled when imem_req=1 and imem_ack=1.
REQ-009 Port: Branch  input  1  conditional-branch control from the decoder.
REQ-010 Port: Uncondbranch  input  1  unconditional-branch control from the decoder.
REQ-011 Port: Zero  input  1  ALU zero flag for the current instruction.
REQ-012 Port: BranchOffset  input  ADDR_W  sign-extended branch offset, in words.
REQ-013 Port: retire  input  1  single-cycle pulse; the datapath has finished the held instruction.
REQ-014 Port: Instruction  output  32  held instruction word.
REQ-015 Port: Opcode  output  11  Instruction[31:21]; feeds the control decoder.
REQ-016 Port: PC  output  ADDR_W  address of the held instruction.
REQ-017 Port: InstrValid  output  1  Instruction, Opcode and PC are valid.
REQ-018 Port: Halted  output  1  the fetch unit has stopped on a halt word.

Function
REQ-019 The FSM SHALL have four states: IDLE, FETCH, HOLD and HALT.
REQ-020 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-021 imem_req SHALL be 1 exactly while in FETCH; imem_addr SHALL always equal PC.
REQ-022 In FETCH with imem_ack=1 the block SHALL register imem_rdata into Instruction.
REQ-023 On that same edge the FSM SHALL go to HOLD, or to HALT if imem_rdata=32'h00000000.
REQ-024 The ack may arrive in the same cycle as the request (zero wait states); otherwise the block SHALL wait in FETCH indefinitely.
REQ-025 InstrValid SHALL be 1 exactly while in HOLD; Instruction, Opcode and PC SHALL be stable throughout HOLD.
REQ-026 In HOLD with retire=1 the block SHALL load next-PC into PC and go to FETCH; InstrValid SHALL drop on the following cycle.
REQ-027 Next-PC SHALL be PC + (BranchOffset << 2) if Uncondbranch=1 or (Branch=1 and Zero=1), else PC + 4.
REQ-028 Branch, Uncondbranch, Zero and BranchOffset SHALL be sampled only on the retire edge.
REQ-029 Next-PC arithmetic SHALL be modulo 2^ADDR_W: wrap-around silently, with negative offsets via two's complement.
REQ-030 PC[1:0] SHALL always be 2'b00, with the low bits of every loaded value forced to zero.
REQ-031 imem_ack outside FETCH and retire outside HOLD SHALL be ignored.
REQ-032 HALT SHALL be left only by Reset; in HALT, Halted=1, InstrValid=0 and imem_req=0.
REQ-033 The minimum instruction period SHALL be two cycles: FETCH with same-cycle ack, then HOLD with retire.

Reset
REQ-034 While Reset=1 the FSM SHALL be forced to IDLE regardless of state, including mid-fetch or in HALT.
REQ-035 While Reset=1 the block SHALL load PC from StartPC with bits [1:0] cleared.
REQ-036 While Reset=1 Instruction SHALL be cleared to 0.
REQ-037 Output values during and immediately after Reset: imem_req=0, InstrValid=0, Halted=0, Opcode=0.
REQ-038 An imem_ack coinciding with Reset SHALL be discarded.

Verification
REQ-039 Reset with StartPC=0x1000, zero-wait memory returning 0xF8400000, retire on every HOLD -> PC sequence 0x1000, 0x1004, 0x1008; Opcode=11'h7C2; InstrValid pulses one cycle per two cycles.
REQ-040 Held instruction at PC=0x2000; retire with Branch=1, Zero=1, BranchOffset=-2 -> next imem_addr=0x1FF8; same case with Zero=0 -> 0x2004.
REQ-041 Uncondbranch=1, BranchOffset=3 at PC=0x40 -> next PC=0x4C; Uncondbranch=1 at PC=0xFFFFFFFFFFFFFFFC with BranchOffset=1 -> PC wraps to 0x0.
REQ-042 imem_ack delayed 5 cycles -> imem_req held high for 5 cycles with constant imem_addr; retire pulses during FETCH have no effect.
REQ-043 Fetched word 0x00000000 -> Halted=1 and imem_req=0 permanently; a following Reset with StartPC=0x80 -> fetching restarts at 0x80.
REQ-044 Reset asserted mid-FETCH together with imem_ack -> Instruction=0, InstrValid=0, PC=StartPC, and no stale data observed after reset.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: fetches one 32-bit word at PC, holds it for the
// datapath until retire, then advances PC sequentially or by a word-offset branch.
module instruction_fetch #(
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] StartPC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              Branch,
  input  logic              Uncondbranch,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] BranchOffset,
  input  logic              retire,
  output logic [31:0]       Instruction,
  output logic [10:0]       Opcode,
  output logic [ADDR_W-1:0] PC,
  output logic              InstrValid,
  output logic              Halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              taken;
  logic [ADDR_W-1:0] next_pc;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= StartPC & ALIGN_MASK;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Branch inputs only matter on the retire edge; modulo arithmetic wraps freely.
  always_comb begin
    taken   = Uncondbranch | (Branch & Zero);
    next_pc = (pc_q + (taken ? (BranchOffset << 2) : WORD_STEP)) & ALIGN_MASK;
  end

  // Next-state and datapath-register update.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = (imem_rdata == 32'h0000_0000) ? HALT : HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of the registered state.
  always_comb begin
    imem_req    = (state_q == FETCH);
    InstrValid  = (state_q == HOLD);
    Halted      = (state_q == HALT);
    imem_addr   = pc_q;
    PC          = pc_q;
    Instruction = instr_q;
    Opcode      = instr_q[31:21];
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a cycle-level behavioural model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch;

  localparam int ADDR_W = 64;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic [ADDR_W-1:0] StartPC = '0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              Branch = 1'b0;
  logic              Uncondbranch = 1'b0;
  logic              Zero = 1'b0;
  logic [ADDR_W-1:0] BranchOffset = '0;
  logic              retire = 1'b0;
  logic [31:0]       Instruction;
  logic [10:0]       Opcode;
  logic [ADDR_W-1:0] PC;
  logic              InstrValid;
  logic              Halted;

  instruction_fetch #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset), .StartPC(StartPC),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Branch(Branch), .Uncondbranch(Uncondbranch), .Zero(Zero),
    .BranchOffset(BranchOffset), .retire(retire),
    .Instruction(Instruction), .Opcode(Opcode), .PC(PC),
    .InstrValid(InstrValid), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch unit must be doing, as plain flags.
  bit          m_known    = 0;
  bit          m_fetching = 0;
  bit          m_valid    = 0;
  bit          m_halted   = 0;
  logic [63:0] m_pc       = '0;
  logic [31:0] m_instr    = '0;

  always @(posedge CLK) begin
    if (Reset) begin
      m_known    = 1;
      m_pc       = {StartPC[63:2], 2'b00};
      m_instr    = '0;
      m_fetching = 0;
      m_valid    = 0;
      m_halted   = 0;
    end else if (m_known && !m_halted) begin
      if (!m_fetching && !m_valid) begin
        m_fetching = 1;                       // idle: start fetching next cycle
      end else if (m_fetching && imem_ack) begin
        m_instr    = imem_rdata;
        m_fetching = 0;
        if (imem_rdata == 32'h0) m_halted = 1;
        else                     m_valid  = 1;
      end else if (m_valid && retire) begin
        if (Uncondbranch || (Branch && Zero)) m_pc = m_pc + BranchOffset * 64'd4;
        else                                  m_pc = m_pc + 64'd4;
        m_pc[1:0]  = 2'b00;
        m_valid    = 0;
        m_fetching = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_known) begin
      check("imem_req",    imem_req,    m_fetching);
      check("imem_addr",   imem_addr,   m_pc);
      check("PC",          PC,          m_pc);
      check("InstrValid",  InstrValid,  m_valid);
      check("Halted",      Halted,      m_halted);
      check("Instruction", Instruction, m_instr);
      check("Opcode",      Opcode,      m_instr[31:21]);
    end
  end

  // Memory responder and retire helper, driven 2 time units after each edge.
  int          ack_delay   = 0;
  bit          mem_en      = 1;
  bit          ack_force   = 0;
  bit          auto_retire = 0;
  int          wait_cnt    = 0;
  logic [31:0] mem_word    = 32'hF840_0000;

  task automatic step();
    @(posedge CLK);
    #2;
    if (imem_req && mem_en) begin
      imem_ack = ack_force || (wait_cnt >= ack_delay);
      wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    end else begin
      imem_ack = ack_force;
      wait_cnt = 0;
    end
    imem_rdata = mem_word;
    if (auto_retire) retire = InstrValid;
  endtask

  task automatic reset_to(input logic [63:0] pc);
    Reset   = 1;
    StartPC = pc;
    retire  = 0;
    step();
    step();
    Reset   = 0;
    StartPC = 64'hDEAD_0000;              // must not matter once reset is released
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !InstrValid; i++) step();
    check("wait_valid_timeout", InstrValid, 1'b1);
  endtask

  task automatic retire_with(input logic br, input logic ub, input logic z, input logic [63:0] off);
    Branch = br; Uncondbranch = ub; Zero = z; BranchOffset = off;
    retire = 1;
    step();
    retire = 0; Branch = 0; Uncondbranch = 0; Zero = 0; BranchOffset = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pcs[$];
    bit          prev_valid;
    int          req_cycles;

    // Reset state and back-to-back zero-wait fetches.
    mem_word = 32'hF840_0000;
    reset_to(64'h1000);
    check("rst_imem_req",   imem_req,   1'b0);
    check("rst_InstrValid", InstrValid, 1'b0);
    check("rst_Halted",     Halted,     1'b0);
    check("rst_Opcode",     Opcode,     11'h000);
    check("rst_PC",         PC,         64'h1000);
    auto_retire = 1;
    prev_valid  = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (InstrValid) pcs.push_back(PC);
      check("valid_not_back_to_back", prev_valid && InstrValid, 1'b0);
      prev_valid = InstrValid;
    end
    check("seq_count", pcs.size() >= 3, 1'b1);
    if (pcs.size() >= 3) begin
      check("seq_pc0", pcs[0], 64'h1000);
      check("seq_pc1", pcs[1], 64'h1004);
      check("seq_pc2", pcs[2], 64'h1008);
    end
    wait_valid();
    check("seq_opcode", Opcode, 11'h7C2);
    auto_retire = 0;
    retire      = 0;

    // Conditional branch taken backwards, then not taken.
    reset_to(64'h2000);
    wait_valid();
    retire_with(1'b1, 1'b0, 1'b1, -64'sd2);
    check("beq_taken_addr", imem_addr, 64'h1FF8);
    reset_to(64'h2000);
    wait_valid();
    retire_with(1'b1, 1'b0, 1'b0, -64'sd2);
    check("beq_not_taken_addr", imem_addr, 64'h2004);
    reset_to(64'h2000);
    wait_valid();
    retire_with(1'b0, 1'b0, 1'b1, 64'd5);
    check("zero_without_branch", imem_addr, 64'h2004);

    // Unconditional branch and wrap-around.
    reset_to(64'h40);
    wait_valid();
    retire_with(1'b0, 1'b1, 1'b0, 64'd3);
    check("ub_addr", imem_addr, 64'h4C);
    reset_to(64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid();
    retire_with(1'b0, 1'b1, 1'b0, 64'd1);
    check("ub_wrap_addr", imem_addr, 64'h0);

    // Wait states with retire pulses that must be ignored during FETCH.
    ack_delay = 4;
    reset_to(64'h300);
    req_cycles = 0;
    for (int i = 0; i < 20 && !InstrValid; i++) begin
      step();
      if (imem_req) begin
        req_cycles++;
        check("wait_addr_const", imem_addr, 64'h300);
        retire = 1;
      end else begin
        retire = 0;
      end
    end
    retire = 0;
    check("wait_req_cycles", req_cycles, 5);
    check("wait_valid_pc", {InstrValid, PC[62:0]}, {1'b1, 63'h300});
    ack_delay = 0;

    // Halt word, stray inputs while halted, then restart by reset.
    mem_word = 32'h0000_0000;
    reset_to(64'h500);
    for (int i = 0; i < 20 && !Halted; i++) step();
    check("halt_reached", Halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      retire    = i[0];
      ack_force = ~i[0];
      step();
      check("halt_no_req", imem_req, 1'b0);
    end
    retire    = 0;
    ack_force = 0;
    check("halt_sticky", {Halted, InstrValid}, 2'b10);
    mem_word = 32'hF840_0000;
    reset_to(64'h80);
    check("restart_halted_clear", Halted, 1'b0);
    step();
    check("restart_req",  imem_req,  1'b1);
    check("restart_addr", imem_addr, 64'h80);
    wait_valid();

    // Reset mid-fetch with a coinciding ack; unaligned StartPC.
    ack_delay = 100;
    reset_to(64'h600);
    step();
    step();
    Reset      = 1;
    StartPC    = 64'h703;
    ack_force  = 1;
    imem_ack   = 1;
    mem_word   = 32'hDEAD_BEEF;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    ack_force = 0;
    imem_ack  = 0;
    Reset     = 0;
    mem_word  = 32'h8B00_0000;
    check("midrst_instr", Instruction, 32'h0);
    check("midrst_valid", InstrValid,  1'b0);
    check("midrst_pc",    PC,          64'h700);
    ack_delay = 0;
    wait_valid();
    check("midrst_fresh_instr", Instruction, 32'h8B00_0000);
    check("midrst_fresh_pc",    PC,          64'h700);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
